// File: rtl/seven_seg_mux_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment display controller:
// segment patterns, brightness width, load-handshake states and a clog2 helper.
package seven_seg_mux_ctrl_pkg;

  // Brightness is a 4-bit duty level compared against the top prescaler bits.
  localparam int BRIGHT_W = 4;

  // All segments off (active-low, {g,f,e,d,c,b,a}).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex glyphs, index = nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Load handshake: EMPTY accepts new contents, PENDING waits for a frame boundary.
  typedef enum logic {
    LD_EMPTY   = 1'b0,
    LD_PENDING = 1'b1
  } ld_state_t;

  // Index width for a digit count; never below 1 so a single digit still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seven_seg_mux_ctrl_if.sv
// Load channel between the datapath (master) and the display controller (slave).
interface seven_seg_mux_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*N_DIGITS-1:0]   value_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     en_in;

  modport master (
    output load_valid, value_in, dp_in, en_in,
    input  load_ready
  );

  modport slave (
    input  load_valid, value_in, dp_in, en_in,
    output load_ready
  );
endinterface

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seven_seg_hex_decode
  import seven_seg_mux_ctrl_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup of the hex glyph.
  always_comb begin
    o_seg = HEX_SEG[i_nibble];
  end

endmodule

// File: rtl/seven_seg_mux_ctrl.sv
// N-digit multiplexed seven-segment controller: prescaler, digit scan,
// frame-synchronous loading, leading-zero blanking and PWM brightness.
module seven_seg_mux_ctrl
  import seven_seg_mux_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SLOT_W   = 17,
  parameter int IDX_W    = clog2_min1(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_mux_ctrl_if.slave   ld,
  input  logic                  lzb,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_frame_done;
  ld_state_t             r_ld_state;
  ld_state_t             w_ld_next;
  logic                  w_capture;
  logic                  w_apply;
  logic                  w_load_ready;
  logic                  w_tick;
  logic                  w_boundary;

  logic [4*N_DIGITS-1:0] r_sh_val;
  logic [N_DIGITS-1:0]   r_sh_dp;
  logic [N_DIGITS-1:0]   r_sh_en;
  logic [4*N_DIGITS-1:0] r_act_val;
  logic [N_DIGITS-1:0]   r_act_dp;
  logic [N_DIGITS-1:0]   r_act_en;

  logic [N_DIGITS-1:0]   w_lz_blank;
  logic [3:0]            w_cur_val;
  logic [6:0]            w_cur_seg;
  logic                  w_pwm_on;
  logic                  w_lit;
  logic [N_DIGITS-1:0]   w_an_sel;

  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  assign w_tick     = &r_cnt;
  assign w_boundary = w_tick && (r_idx == LAST_IDX);

  // Free-running slot prescaler and digit index with explicit wrap for non-power-of-two counts.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + SLOT_W'(1);
      r_frame_done <= w_boundary;
      if (w_tick) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Load handshake state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ld_state <= LD_EMPTY;
    else        r_ld_state <= w_ld_next;
  end

  // Handshake next state: capture while empty, apply to the display at a frame boundary.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_ld_next    = r_ld_state;
    w_capture    = 1'b0;
    w_apply      = 1'b0;
    w_load_ready = 1'b0;
    case (r_ld_state)
      LD_EMPTY: begin
        w_load_ready = 1'b1;
        if (ld.load_valid) begin
          w_capture = 1'b1;
          w_ld_next = LD_PENDING;
        end
      end
      LD_PENDING: begin
        if (w_boundary) begin
          w_apply   = 1'b1;
          w_ld_next = LD_EMPTY;
        end
      end
    endcase
  end

  assign ld.load_ready = w_load_ready;

  // Shadow capture on transfer, shadow-to-active copy on the boundary that ends a frame.
  // NOTE: these data registers are reset so the display stays dark until the first load lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_sh_en   <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_act_en  <= '0;
    end else begin
      if (w_capture) begin
        r_sh_val <= ld.value_in;
        r_sh_dp  <= ld.dp_in;
        r_sh_en  <= ld.en_in;
      end
      if (w_apply) begin
        r_act_val <= r_sh_val;
        r_act_dp  <= r_sh_dp;
        r_act_en  <= r_sh_en;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit, blanking enabled zeros until a nonzero
  // enabled digit ends the run; disabled digits are skipped and digit 0 always shows.
  always_comb begin
    logic run;
    run        = 1'b1;
    w_lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (r_act_en[i]) begin
        if (run && (r_act_val[4*i +: 4] == 4'h0)) w_lz_blank[i] = 1'b1;
        else                                      run           = 1'b0;
      end
    end
    if (!lzb) w_lz_blank = '0;
  end

  assign w_cur_val = r_act_val[{r_idx, 2'b00} +: 4];
  assign w_pwm_on  = (r_cnt[SLOT_W-1 -: BRIGHT_W] <= brightness);
  assign w_lit     = r_act_en[r_idx] && !w_lz_blank[r_idx] && w_pwm_on;
  assign w_an_sel  = N_DIGITS'(1) << r_idx;

  seven_seg_hex_decode u_hex_decode (
    .i_nibble (w_cur_val),
    .o_seg    (w_cur_seg)
  );

  // Registered pin drivers: selected digit when lit, otherwise everything dark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_lit) begin
      r_an  <= ~w_an_sel;
      r_seg <= w_cur_seg;
      r_dp  <= ~r_act_dp[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
